// File: rtl/ysyx_040729_div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divider sequencer: FSM encodings,
// default widths and the EXU op-decode bit positions for {signed, word, rem}.
package ysyx_040729_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int XLEN_DEF = 64;
  localparam int WLEN_DEF = 32;

  // Bit positions inside the 3-bit divide op code the EXU forwards.
  localparam int OP_SIGNED_BIT = 2;
  localparam int OP_WORD_BIT   = 1;
  localparam int OP_REM_BIT    = 0;

endpackage

// File: rtl/ysyx_040729_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left by one, then
// keep the trial difference when the divisor fits.
module ysyx_040729_div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0]   shifted;
  logic [W+1:0] diff;
  logic         borrow;

  // The shifted remainder needs W+1 bits; one more bit exposes the borrow.
  assign shifted = {rem, quo[W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign borrow  = diff[W+1];

  assign rem_next = borrow ? shifted[W-1:0] : diff[W-1:0];
  assign quo_next = {quo[W-2:0], ~borrow};

endmodule

// File: rtl/ysyx_040729_div_ctrl.sv
// Multi-cycle DIV/DIVU/REM/REMU (+W) sequencer: sign normalisation, one
// quotient bit per cycle, RISC-V special cases, sign fix and W sign-extension.
module ysyx_040729_div_ctrl
  import ysyx_040729_div_ctrl_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int WLEN = WLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_dividend,
  input  logic [XLEN-1:0] in_divisor,
  input  logic            in_signed,
  input  logic            in_word,
  input  logic            in_rem,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]} : v;
  endfunction

  div_state_t state;
  logic [XLEN-1:0]  rem, quo, dvs, result;
  logic [CNT_W-1:0] cnt;
  logic             word, rem_sel, neg_q, neg_r;

  logic signed [XLEN-1:0] dvd_ext, dvs_ext;
  logic [XLEN-1:0] abs_dvd, abs_dvs, most_neg, special_res, rem_nx, quo_nx;
  logic            dvd_neg, dvs_neg, div_zero, ovf;

  // W ops see only the low WLEN bits, widened per signedness.
  always_comb begin
    dvd_ext  = in_dividend;
    dvs_ext  = in_divisor;
    most_neg = {1'b1, {(XLEN-1){1'b0}}};
    if (in_word) begin
      dvd_ext  = in_signed ? {{(XLEN-WLEN){in_dividend[WLEN-1]}}, in_dividend[WLEN-1:0]}
                           : {{(XLEN-WLEN){1'b0}}, in_dividend[WLEN-1:0]};
      dvs_ext  = in_signed ? {{(XLEN-WLEN){in_divisor[WLEN-1]}}, in_divisor[WLEN-1:0]}
                           : {{(XLEN-WLEN){1'b0}}, in_divisor[WLEN-1:0]};
      most_neg = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    end
  end

  assign dvd_neg  = in_signed & dvd_ext[XLEN-1];
  assign dvs_neg  = in_signed & dvs_ext[XLEN-1];
  assign abs_dvd  = neg_if(dvd_ext, dvd_neg);
  assign abs_dvs  = neg_if(dvs_ext, dvs_neg);
  assign div_zero = (dvs_ext == '0);
  assign ovf      = in_signed && (dvd_ext == most_neg) && (dvs_ext == '1);

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = in_rem ? dvd_ext : '1;
    else if (!in_rem)
      special_res = dvd_ext;
    special_res = fit_word(special_res, in_word);
  end

  ysyx_040729_div_step #(.W(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      result  <= '0;
      cnt     <= '0;
      word    <= 1'b0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            word    <= in_word;
            rem_sel <= in_rem;
            neg_q   <= dvd_neg ^ dvs_neg;
            neg_r   <= dvd_neg;
            if (div_zero || ovf) begin
              result <= special_res;
              state  <= DONE;
            end else begin
              rem   <= '0;
              // A W dividend sits in the top WLEN bits so WLEN shifts consume it.
              quo   <= in_word ? (abs_dvd << (XLEN - WLEN)) : abs_dvd;
              dvs   <= abs_dvs;
              cnt   <= in_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1))
              state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fit_word(rem_sel ? neg_if(rem, neg_r) : neg_if(quo, neg_q), word);
            state  <= DONE;
          end
        end
        DONE: begin
          if (flush || out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = result;

endmodule

// File: tb/tb_ysyx_040729_div_ctrl.sv
// Directed bench for the divider sequencer: results go through a scoreboard
// queue popped by a monitor on each output handshake.
module tb_ysyx_040729_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [63:0] in_dividend, in_divisor;
  logic        in_signed, in_word, in_rem;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        busy;

  int n_run  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  ysyx_040729_div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .in_divisor  (in_divisor),
    .in_signed   (in_signed),
    .in_word     (in_word),
    .in_rem      (in_rem),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected result.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", out_result);
      end else begin
        check("result", out_result, exp_q.pop_front());
      end
    end
  end

  // Present a request now (just after an edge) and let the next edge accept it.
  task automatic issue_now(input string name, input logic [63:0] dvd, input logic [63:0] dvs,
                           input logic s, input logic w, input logic r,
                           input logic [63:0] expv, input logic push);
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    in_dividend = dvd;
    in_divisor  = dvs;
    in_signed   = s;
    in_word     = w;
    in_rem      = r;
    in_valid    = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    in_dividend = 64'hA5A5_A5A5_A5A5_A5A5;
    in_divisor  = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  // Accept edge counts as edge 1; returns once out_valid is seen.
  task automatic wait_out(input string name, input int lat);
    int n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
  endtask

  task automatic do_op(input string name, input logic [63:0] dvd, input logic [63:0] dvs,
                       input logic s, input logic w, input logic r,
                       input logic [63:0] expv, input int lat);
    @(posedge clk); #1;
    issue_now(name, dvd, dvs, s, w, r, expv, 1'b1);
    wait_out(name, lat);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_dividend = '0; in_divisor = '0; in_signed = 1'b0; in_word = 1'b0; in_rem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  {63'd0, in_ready},  64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_busy",      {63'd0, busy},      64'd0);
    check("reset_result",    out_result,         64'd0);
    rst = 1'b1;

    do_op("divu",    64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, 66);
    do_op("remu",    64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2,  66);
    do_op("div_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    do_op("rem_neg", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    do_op("divu_z",  64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem_z",   64'h1234, 64'd0, 1'b1, 1'b0, 1'b1, 64'h1234, 1);
    do_op("divw_ov", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
          64'hFFFF_FFFF_8000_0000, 1);
    do_op("divuw",   64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    do_op("div_ov",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
          64'h8000_0000_0000_0000, 1);
    do_op("divw",    64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0003, 1'b1, 1'b1, 1'b0,
          64'hFFFF_FFFF_FFFF_FFFE, 34);
    do_op("remw",    64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0003, 1'b1, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 34);
    do_op("divu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 1'b0, 64'h0FFF_FFFF_FFFF_FFFF, 66);
    do_op("remu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b0, 1'b1, 64'hF, 66);

    // Back-pressure: result held while out_ready is low.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue_now("hold", 64'd1000, 64'd10, 1'b0, 1'b1, 1'b0, 64'd100, 1'b1);
    wait_out("hold", 34);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_result",    out_result,          64'd100);
      check("hold_in_ready",  {63'd0, in_ready},   64'd0);
      check("hold_out_valid", {63'd0, out_valid},  64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_idle", {63'd0, in_ready}, 64'd1);
    issue_now("after_hold", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0, 64'd3, 1'b1);
    check("after_hold_busy", {63'd0, busy}, 64'd1);
    wait_out("after_hold", 66);

    // Flush in IDLE blocks a simultaneous request.
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", {63'd0, busy}, 64'd0);

    // Flush during CALC discards the operation.
    @(posedge clk); #1;
    issue_now("flush", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    check("flush_in_calc", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      check("flush_no_output", {63'd0, seen}, 64'd0);
    end
    do_op("post_flush", 64'd77, 64'd7, 1'b0, 1'b0, 1'b0, 64'd11, 66);

    // Reset mid-CALC returns every output to its reset value.
    @(posedge clk); #1;
    issue_now("rst_mid", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_busy",      {63'd0, busy},      64'd0);
    check("rst_mid_result",    out_result,         64'd0);
    rst = 1'b1;
    do_op("post_rst", 64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0, 1'b0, 64'd4, 66);

    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
